// File: rtl/bp_me_pkg.sv
// Shared definitions for the memory-engine DRAM command arbiter:
// header length field position, arbiter state encoding and a safe clog2.
package bp_me_pkg;

    // Header length field sits in the low bits of the first flit.
    localparam int unsigned hdr_len_lsb_gp = 0;

    typedef enum logic {
        e_arb_idle  = 1'b0,
        e_arb_burst = 1'b1
    } arb_state_e;

    // clog2 that never returns 0, so a single-entry index is still one bit wide.
    function automatic int unsigned safe_clog2(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bsg_arb_round_robin.sv
// Round-robin arbiter: grants the first requester after the last winner.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   reqs       : per-requester request vector
//   hold       : freeze the pointer and suppress new grants (burst in progress)
//   yumi       : the current grant was consumed; advance the pointer to it
//   grants_c   : one-hot grant (combinational)
//   tag_c      : index of the granted requester (combinational)
//   v_c        : some requester is granted (combinational)
module bsg_arb_round_robin
    import bp_me_pkg::*;
#(
    parameter int unsigned width_p     = 4,
    parameter int unsigned tag_width_p = safe_clog2(width_p)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [width_p-1:0]     reqs,
    input  logic                   hold,
    input  logic                   yumi,
    output logic [width_p-1:0]     grants_c,
    output logic [tag_width_p-1:0] tag_c,
    output logic                   v_c
);

    logic [tag_width_p-1:0] last_r;
    logic [31:0]            idx;

    // Pointer resets to the last requester so requester 0 has first priority.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_r <= tag_width_p'(width_p - 1);
        end else if (yumi && !hold) begin
            last_r <= tag_c;
        end
    end

    // Scan from last_r+1 around to last_r; first hit wins.
    always_comb begin
        tag_c = '0;
        v_c   = 1'b0;
        idx   = '0;
        if (!hold) begin
            for (int unsigned i = 1; i <= width_p; i++) begin
                idx = (32'(last_r) + i) % width_p;
                if (!v_c && reqs[tag_width_p'(idx)]) begin
                    v_c   = 1'b1;
                    tag_c = tag_width_p'(idx);
                end
            end
        end
        grants_c = v_c ? (width_p'(1) << tag_c) : '0;
    end

endmodule

// File: rtl/bp_me_dram_cmd_arbiter.sv
// Shares the DRAM command link among num_src_p memory-command sources.
// Round-robin at packet granularity, grant held for all flits of a burst,
// per-source outstanding-command limit, responses routed back by source id.
// Ports:
//   mem_clk_i, mem_reset_n_i         : clock, synchronous active-low reset
//   cmd_v_i/cmd_data_i/cmd_ready_o   : per-source command flits in
//   dram_cmd_v_o/_data_o/_src_o/_ready_i : granted flit out with source tag
//   dram_resp_v_i/_data_i/_src_i/_ready_o: single-flit responses in
//   resp_v_o/resp_data_o/resp_ready_i: one-hot response out, data broadcast
//   error_o                          : sticky protocol error
module bp_me_dram_cmd_arbiter
    import bp_me_pkg::*;
#(
    parameter int unsigned num_src_p    = 4,
    parameter int unsigned flit_width_p = 64,
    parameter int unsigned len_width_p  = 4,
    parameter int unsigned max_out_p    = 8,
    parameter int unsigned src_width_p  = safe_clog2(num_src_p)
) (
    input  logic                              mem_clk_i,
    input  logic                              mem_reset_n_i,
    input  logic [num_src_p-1:0]              cmd_v_i,
    input  logic [num_src_p*flit_width_p-1:0] cmd_data_i,
    output logic [num_src_p-1:0]              cmd_ready_o,
    output logic                              dram_cmd_v_o,
    output logic [flit_width_p-1:0]           dram_cmd_data_o,
    output logic [src_width_p-1:0]            dram_cmd_src_o,
    input  logic                              dram_cmd_ready_i,
    input  logic                              dram_resp_v_i,
    input  logic [flit_width_p-1:0]           dram_resp_data_i,
    input  logic [src_width_p-1:0]            dram_resp_src_i,
    output logic                              dram_resp_ready_o,
    output logic [num_src_p-1:0]              resp_v_o,
    output logic [flit_width_p-1:0]           resp_data_o,
    input  logic [num_src_p-1:0]              resp_ready_i,
    output logic                              error_o
);

    localparam int unsigned cnt_width_lp = $clog2(max_out_p + 1);

    arb_state_e                state_r, state_n;
    logic [src_width_p-1:0]    src_r, src_n, sel;
    logic [len_width_p-1:0]    rem_r, rem_n, hdr_len;
    logic [cnt_width_lp-1:0]   count_r [num_src_p];
    logic [flit_width_p-1:0]   flits   [num_src_p];
    logic [flit_width_p-1:0]   sel_flit;
    logic [num_src_p-1:0]      eligible, arb_grants, zero_hit;
    logic [src_width_p-1:0]    arb_tag;
    logic                      arb_v, hdr_hs, resp_hs, resp_src_ok, err_r;

    // Unpack the flattened per-source command flits.
    for (genvar g = 0; g < num_src_p; g++) begin : g_flit
        assign flits[g] = cmd_data_i[g*flit_width_p +: flit_width_p];
    end

    // During a burst the latched source is connected; otherwise the arbiter winner.
    assign sel             = (state_r == e_arb_burst) ? src_r : arb_tag;
    assign sel_flit        = flits[sel];
    assign hdr_len         = sel_flit[hdr_len_lsb_gp +: len_width_p];
    assign dram_cmd_data_o = sel_flit;
    assign dram_cmd_src_o  = sel;

    bsg_arb_round_robin #(
        .width_p     (num_src_p),
        .tag_width_p (src_width_p)
    ) u_arb (
        .clk      (mem_clk_i),
        .rst_n    (mem_reset_n_i),
        .reqs     (eligible),
        .hold     (state_r == e_arb_burst),
        .yumi     (hdr_hs),
        .grants_c (arb_grants),
        .tag_c    (arb_tag),
        .v_c      (arb_v)
    );

    // FSM state and burst bookkeeping.
    always_ff @(posedge mem_clk_i) begin
        if (!mem_reset_n_i) begin
            state_r <= e_arb_idle;
            src_r   <= '0;
            rem_r   <= '0;
        end else begin
            state_r <= state_n;
            src_r   <= src_n;
            rem_r   <= rem_n;
        end
    end

    // Next state and command-side handshake; everything quiet while in reset.
    always_comb begin
        state_n      = state_r;
        src_n        = src_r;
        rem_n        = rem_r;
        dram_cmd_v_o = 1'b0;
        cmd_ready_o  = '0;
        hdr_hs       = 1'b0;
        if (mem_reset_n_i) begin
            case (state_r)
                e_arb_idle: begin
                    dram_cmd_v_o = arb_v;
                    cmd_ready_o  = arb_grants & {num_src_p{dram_cmd_ready_i}};
                    hdr_hs       = arb_v & dram_cmd_ready_i;
                    if (hdr_hs && (hdr_len != '0)) begin
                        state_n = e_arb_burst;
                        src_n   = arb_tag;
                        rem_n   = hdr_len;
                    end
                end
                e_arb_burst: begin
                    dram_cmd_v_o        = cmd_v_i[src_r];
                    cmd_ready_o[src_r]  = dram_cmd_ready_i;
                    if (cmd_v_i[src_r] && dram_cmd_ready_i) begin
                        rem_n = rem_r - len_width_p'(1);
                        if (rem_r == len_width_p'(1)) begin
                            state_n = e_arb_idle;
                        end
                    end
                end
                default: state_n = e_arb_idle;
            endcase
        end
    end

    // Response routing; out-of-range ids are swallowed.
    assign resp_src_ok = (32'(dram_resp_src_i) < num_src_p);
    assign resp_data_o = dram_resp_data_i;
    assign resp_hs     = dram_resp_v_i & dram_resp_ready_o;

    always_comb begin
        resp_v_o          = '0;
        dram_resp_ready_o = 1'b0;
        if (mem_reset_n_i) begin
            if (resp_src_ok) begin
                resp_v_o          = num_src_p'(dram_resp_v_i) << dram_resp_src_i;
                dram_resp_ready_o = resp_ready_i[dram_resp_src_i];
            end else begin
                dram_resp_ready_o = 1'b1;
            end
        end
    end

    // Per-source outstanding counters: +1 per header, -1 per response.
    for (genvar g = 0; g < num_src_p; g++) begin : g_cnt
        logic inc, dec, resp_hit;

        assign eligible[g]  = cmd_v_i[g] & (count_r[g] != cnt_width_lp'(max_out_p));
        assign inc          = hdr_hs & (arb_tag == src_width_p'(g));
        assign resp_hit     = resp_hs & resp_src_ok & (dram_resp_src_i == src_width_p'(g));
        assign dec          = resp_hit & (count_r[g] != '0);
        assign zero_hit[g]  = resp_hit & (count_r[g] == '0);

        always_ff @(posedge mem_clk_i) begin
            if (!mem_reset_n_i) begin
                count_r[g] <= '0;
            end else if (inc && !dec) begin
                count_r[g] <= count_r[g] + cnt_width_lp'(1);
            end else if (dec && !inc) begin
                count_r[g] <= count_r[g] - cnt_width_lp'(1);
            end
        end
    end

    // Sticky error: bad response id or response with nothing outstanding.
    always_ff @(posedge mem_clk_i) begin
        if (!mem_reset_n_i) begin
            err_r <= 1'b0;
        end else if ((resp_hs && !resp_src_ok) || (|zero_hit)) begin
            err_r <= 1'b1;
        end
    end

    assign error_o = err_r;

endmodule
